// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback and drives datapath selects.
// Ports: clk, rstn (async active-low), opcode[6:0], mem_ready, branch_taken;
//   alu_a_src[2:0], alu_b_src[1:0], alu_op[1:0], result_src[1:0], pc_src,
//   addr_src, pc_we, ir_we, rf_we, mem_req, mem_we, illegal.
// Optional: `define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN sends unknown opcodes to a
//   sticky TRAP state and raises illegal; otherwise they act as a NOP.
module multicycle_ctrl #(
  parameter int RESET_STATE_FETCH = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic [2:0] alu_a_src,
  output logic [1:0] alu_b_src,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       pc_src,
  output logic       addr_src,
  output logic       pc_we,
  output logic       ir_we,
  output logic       rf_we,
  output logic       mem_req,
  output logic       mem_we,
  output logic       illegal
);

  if (RESET_STATE_FETCH != 1) begin : g_bad_reset_state
    $error("multicycle_ctrl: only RESET_STATE_FETCH=1 is supported");
  end

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_EXEC_R    = 4'd2;
  localparam logic [3:0] S_EXEC_I    = 4'd3;
  localparam logic [3:0] S_LUI       = 4'd4;
  localparam logic [3:0] S_AUIPC     = 4'd5;
  localparam logic [3:0] S_ALU_WB    = 4'd6;
  localparam logic [3:0] S_MEM_ADDR  = 4'd7;
  localparam logic [3:0] S_MEM_LOAD  = 4'd8;
  localparam logic [3:0] S_MEM_WB    = 4'd9;
  localparam logic [3:0] S_MEM_STORE = 4'd10;
  localparam logic [3:0] S_BRANCH    = 4'd11;
  localparam logic [3:0] S_JAL       = 4'd12;
  localparam logic [3:0] S_JALR_ADDR = 4'd13;
  localparam logic [3:0] S_JALR_LINK = 4'd14;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  localparam logic [3:0] S_TRAP      = 4'd15;
`endif

  logic [3:0] state_q, state_d;

  logic op_r, op_i, op_ld, op_st, op_br;
  logic op_jal, op_jalr, op_lui, op_auipc;

  assign op_r     = opcode == 7'b0110011;
  assign op_i     = opcode == 7'b0010011;
  assign op_ld    = opcode == 7'b0000011;
  assign op_st    = opcode == 7'b0100011;
  assign op_br    = opcode == 7'b1100011;
  assign op_jal   = opcode == 7'b1101111;
  assign op_jalr  = opcode == 7'b1100111;
  assign op_lui   = opcode == 7'b0110111;
  assign op_auipc = opcode == 7'b0010111;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          op_r:                state_d = S_EXEC_R;
          op_i:                state_d = S_EXEC_I;
          op_ld, op_st:        state_d = S_MEM_ADDR;
          op_br:               state_d = S_BRANCH;
          op_jal:              state_d = S_JAL;
          op_jalr:             state_d = S_JALR_ADDR;
          op_lui:              state_d = S_LUI;
          op_auipc:            state_d = S_AUIPC;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          default:             state_d = S_TRAP;
`else
          default:             state_d = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R,
      S_EXEC_I,
      S_LUI,
      S_AUIPC:     state_d = S_ALU_WB;
      S_MEM_ADDR:  state_d = opcode[5] ? S_MEM_STORE : S_MEM_LOAD;
      S_MEM_LOAD:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_STORE: if (mem_ready) state_d = S_FETCH;
      S_JALR_ADDR: state_d = S_JALR_LINK;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:      state_d = S_TRAP;
`endif
      default:     state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  logic pc_we_c, ir_we_c, rf_we_c, mem_req_c, mem_we_c;

  always_comb begin
    alu_a_src  = 3'd0;
    alu_b_src  = 2'd2;
    alu_op     = 2'd0;
    result_src = 2'd0;
    pc_src     = 1'b0;
    addr_src   = 1'b0;
    pc_we_c    = 1'b0;
    ir_we_c    = 1'b0;
    rf_we_c    = 1'b0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        pc_we_c   = mem_ready;
        ir_we_c   = mem_ready;
      end
      S_DECODE,
      S_AUIPC: begin
        alu_a_src = 3'd1;
        alu_b_src = 2'd1;
      end
      S_EXEC_R: begin
        alu_a_src = 3'd2;
        alu_b_src = 2'd0;
        alu_op    = 2'd2;
      end
      S_EXEC_I: begin
        alu_a_src = 3'd2;
        alu_b_src = 2'd1;
        alu_op    = 2'd2;
      end
      S_LUI: begin
        alu_a_src = 3'd4;
        alu_b_src = 2'd1;
      end
      S_ALU_WB: rf_we_c = 1'b1;
      S_MEM_ADDR,
      S_JALR_ADDR: begin
        alu_a_src = 3'd2;
        alu_b_src = 2'd1;
      end
      S_MEM_LOAD: begin
        mem_req_c = 1'b1;
        addr_src  = 1'b1;
      end
      S_MEM_WB: begin
        rf_we_c    = 1'b1;
        result_src = 2'd1;
      end
      S_MEM_STORE: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        addr_src  = 1'b1;
      end
      S_BRANCH: begin
        alu_a_src = 3'd2;
        alu_b_src = 2'd0;
        alu_op    = 2'd1;
        pc_src    = 1'b1;
        pc_we_c   = branch_taken;
      end
      S_JAL,
      S_JALR_LINK: begin
        alu_a_src  = 3'd1;
        rf_we_c    = 1'b1;
        result_src = 2'd2;
        pc_we_c    = 1'b1;
        pc_src     = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are masked by rstn so a reset mid-access drops them at once.
  assign pc_we   = pc_we_c   & rstn;
  assign ir_we   = ir_we_c   & rstn;
  assign rf_we   = rf_we_c   & rstn;
  assign mem_req = mem_req_c & rstn;
  assign mem_we  = mem_we_c  & rstn;

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  assign illegal_d = illegal_q | (state_d == S_TRAP);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for the multicycle control FSM.
// Expected per-cycle output vectors are queued with stimulus and checked.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rstn;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       branch_taken;
  logic [2:0] alu_a_src;
  logic [1:0] alu_b_src;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic       pc_src;
  logic       addr_src;
  logic       pc_we;
  logic       ir_we;
  logic       rf_we;
  logic       mem_req;
  logic       mem_we;
  logic       illegal;

  multicycle_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .alu_a_src    (alu_a_src),
    .alu_b_src    (alu_b_src),
    .alu_op       (alu_op),
    .result_src   (result_src),
    .pc_src       (pc_src),
    .addr_src     (addr_src),
    .pc_we        (pc_we),
    .ir_we        (ir_we),
    .rf_we        (rf_we),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  // Vector: a[16:14] b[13:12] op[11:10] res[9:8] pcs[7] adr[6]
  //         pc_we[5] ir_we[4] rf_we[3] mem_req[2] mem_we[1] illegal[0]
  typedef struct packed {
    logic [16:0] v;
    logic [16:0] m;
  } exp_t;

  typedef struct packed {
    logic [6:0] op;
    logic       mr;
    logic       bt;
  } stim_t;

  exp_t  exp_q[$];
  stim_t stim_q[$];
  int    checks   = 0;
  int    failures = 0;
  logic  ill_exp  = 1'b0;

  function automatic logic [16:0] obs();
    return {alu_a_src, alu_b_src, alu_op, result_src, pc_src, addr_src,
            pc_we, ir_we, rf_we, mem_req, mem_we, illegal};
  endfunction

  // Negative field value means the field is not constrained in that state.
  function automatic exp_t e(int a, int b, int op, int rs, int ps, int ad,
                             int pw, int iw, int rw, int mq, int mw);
    exp_t x;
    x.v = '0;
    x.m = '0;
    if (a >= 0)  begin x.v[16:14] = 3'(a);  x.m[16:14] = '1; end
    if (b >= 0)  begin x.v[13:12] = 2'(b);  x.m[13:12] = '1; end
    if (op >= 0) begin x.v[11:10] = 2'(op); x.m[11:10] = '1; end
    if (rs >= 0) begin x.v[9:8]   = 2'(rs); x.m[9:8]   = '1; end
    if (ps >= 0) begin x.v[7]     = 1'(ps); x.m[7]     = 1'b1; end
    if (ad >= 0) begin x.v[6]     = 1'(ad); x.m[6]     = 1'b1; end
    x.v[5:1] = {1'(pw), 1'(iw), 1'(rw), 1'(mq), 1'(mw)};
    x.m[5:1] = '1;
    x.v[0]   = ill_exp;
    x.m[0]   = 1'b1;
    return x;
  endfunction

  function automatic exp_t f_rdy();  return e(0,2,0,-1,0,0,1,1,0,1,0); endfunction
  function automatic exp_t f_wait(); return e(0,2,0,-1,0,0,0,0,0,1,0); endfunction
  function automatic exp_t s_dec();  return e(1,1,0,-1,-1,-1,0,0,0,0,0); endfunction
  function automatic exp_t s_exr();  return e(2,0,2,-1,-1,-1,0,0,0,0,0); endfunction
  function automatic exp_t s_exi();  return e(2,1,2,-1,-1,-1,0,0,0,0,0); endfunction
  function automatic exp_t s_lui();  return e(4,1,0,-1,-1,-1,0,0,0,0,0); endfunction
  function automatic exp_t s_aui();  return e(1,1,0,-1,-1,-1,0,0,0,0,0); endfunction
  function automatic exp_t s_wb();   return e(-1,-1,-1,0,-1,-1,0,0,1,0,0); endfunction
  function automatic exp_t s_madr(); return e(2,1,0,-1,-1,-1,0,0,0,0,0); endfunction
  function automatic exp_t s_mld();  return e(-1,-1,-1,-1,-1,1,0,0,0,1,0); endfunction
  function automatic exp_t s_mwb();  return e(-1,-1,-1,1,-1,-1,0,0,1,0,0); endfunction
  function automatic exp_t s_mst();  return e(-1,-1,-1,-1,-1,1,0,0,0,1,1); endfunction
  function automatic exp_t s_br(int t); return e(2,0,1,-1,1,-1,t,0,0,0,0); endfunction
  function automatic exp_t s_link(); return e(1,2,0,2,1,-1,1,0,1,0,0); endfunction
  function automatic exp_t s_jadr(); return e(2,1,0,-1,-1,-1,0,0,0,0,0); endfunction
  function automatic exp_t s_trap(); return e(-1,-1,-1,-1,-1,-1,0,0,0,0,0); endfunction

  task automatic push(input logic [6:0] op, input logic mr, input logic bt,
                      input exp_t x);
    stim_q.push_back('{op: op, mr: mr, bt: bt});
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    logic [16:0] o;
    rstn = 1'b0;
    mem_ready = 1'b1;
    branch_taken = 1'b1;
    opcode = OP_I;
    repeat (2) @(posedge clk);
    @(negedge clk);
    o = obs();
    checks++;
    if (o[5:0] !== 6'b0) begin
      failures++;
      $display("FAIL rst_strobes got=%b want=000000", o[5:0]);
    end
    checks++;
    if (o[16:10] !== 7'b000_10_00) begin
      failures++;
      $display("FAIL rst_sel got=%b want=0001000", o[16:10]);
    end
    rstn = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_fetch_wait got=%b want=1", mem_req);
    end
    #2;
    rstn = 1'b0;
    mem_ready = 1'b1;
    #1;
    o = obs();
    checks++;
    if (o[5:1] !== 5'b0) begin
      failures++;
      $display("FAIL rst_mid_access got=%b want=00000", o[5:1]);
    end
    @(negedge clk);
    rstn = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    o = obs();
    checks++;
    if ((o & f_wait().m) !== (f_wait().v & f_wait().m)) begin
      failures++;
      $display("FAIL rst_release got=%h want=%h", o & f_wait().m,
               f_wait().v & f_wait().m);
    end
  endtask

  task automatic test_alu_ops();
    exp_t x;
    stim_t s;
    int cyc = 0;
    push(OP_I, 1, 0, f_rdy());  push(OP_I, 1, 0, s_dec());
    push(OP_I, 1, 0, s_exi());  push(OP_I, 1, 0, s_wb());
    push(OP_R, 1, 0, f_rdy());  push(OP_R, 0, 0, s_dec());
    push(OP_R, 0, 0, s_exr());  push(OP_R, 0, 0, s_wb());
    push(OP_LUI, 0, 0, f_wait()); push(OP_LUI, 1, 0, f_rdy());
    push(OP_LUI, 1, 0, s_dec());  push(OP_LUI, 1, 0, s_lui());
    push(OP_LUI, 1, 0, s_wb());
    push(OP_AUIPC, 1, 0, f_rdy()); push(OP_AUIPC, 1, 0, s_dec());
    push(OP_AUIPC, 1, 0, s_aui()); push(OP_AUIPC, 1, 0, s_wb());
    push(OP_AUIPC, 0, 0, f_wait());
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front();
      opcode = s.op; mem_ready = s.mr; branch_taken = s.bt;
      @(negedge clk);
      x = exp_q.pop_front();
      checks++;
      if ((obs() & x.m) !== (x.v & x.m)) begin
        failures++;
        $display("FAIL alu_ops cyc=%0d got=%h want=%h", cyc,
                 obs() & x.m, x.v & x.m);
      end
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_load();
    exp_t x;
    stim_t s;
    int cyc = 0;
    push(OP_LD, 1, 0, f_rdy());  push(OP_LD, 1, 0, s_dec());
    push(OP_LD, 1, 0, s_madr());
    push(OP_LD, 0, 0, s_mld());  push(OP_LD, 0, 0, s_mld());
    push(OP_LD, 0, 0, s_mld());  push(OP_LD, 1, 0, s_mld());
    push(OP_LD, 1, 0, s_mwb());  push(OP_LD, 0, 0, f_wait());
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front();
      opcode = s.op; mem_ready = s.mr; branch_taken = s.bt;
      @(negedge clk);
      x = exp_q.pop_front();
      checks++;
      if ((obs() & x.m) !== (x.v & x.m)) begin
        failures++;
        $display("FAIL load cyc=%0d got=%h want=%h", cyc,
                 obs() & x.m, x.v & x.m);
      end
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_store();
    exp_t x;
    stim_t s;
    int cyc = 0;
    push(OP_ST, 1, 0, f_rdy());  push(OP_ST, 0, 0, s_dec());
    push(OP_ST, 0, 0, s_madr()); push(OP_ST, 0, 0, s_mst());
    push(OP_ST, 1, 0, s_mst());  push(OP_ST, 0, 0, f_wait());
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front();
      opcode = s.op; mem_ready = s.mr; branch_taken = s.bt;
      @(negedge clk);
      x = exp_q.pop_front();
      checks++;
      if ((obs() & x.m) !== (x.v & x.m)) begin
        failures++;
        $display("FAIL store cyc=%0d got=%h want=%h", cyc,
                 obs() & x.m, x.v & x.m);
      end
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_branch();
    exp_t x;
    stim_t s;
    int cyc = 0;
    push(OP_BR, 1, 1, f_rdy()); push(OP_BR, 1, 1, s_dec());
    push(OP_BR, 1, 1, s_br(1));
    push(OP_BR, 1, 0, f_rdy()); push(OP_BR, 1, 0, s_dec());
    push(OP_BR, 1, 0, s_br(0)); push(OP_BR, 0, 0, f_wait());
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front();
      opcode = s.op; mem_ready = s.mr; branch_taken = s.bt;
      @(negedge clk);
      x = exp_q.pop_front();
      checks++;
      if ((obs() & x.m) !== (x.v & x.m)) begin
        failures++;
        $display("FAIL branch cyc=%0d got=%h want=%h", cyc,
                 obs() & x.m, x.v & x.m);
      end
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_jump();
    exp_t x;
    stim_t s;
    int cyc = 0;
    push(OP_JAL, 1, 0, f_rdy());  push(OP_JAL, 1, 0, s_dec());
    push(OP_JAL, 1, 0, s_link());
    push(OP_JALR, 1, 0, f_rdy()); push(OP_JALR, 1, 0, s_dec());
    push(OP_JALR, 1, 0, s_jadr()); push(OP_JALR, 1, 0, s_link());
    push(OP_JALR, 0, 0, f_wait());
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front();
      opcode = s.op; mem_ready = s.mr; branch_taken = s.bt;
      @(negedge clk);
      x = exp_q.pop_front();
      checks++;
      if ((obs() & x.m) !== (x.v & x.m)) begin
        failures++;
        $display("FAIL jump cyc=%0d got=%h want=%h", cyc,
                 obs() & x.m, x.v & x.m);
      end
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_illegal();
    exp_t x;
    stim_t s;
    int cyc = 0;
    push(OP_BAD, 1, 0, f_rdy()); push(OP_BAD, 1, 0, s_dec());
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    ill_exp = 1'b1;
    push(OP_BAD, 1, 1, s_trap()); push(OP_I, 1, 1, s_trap());
    push(OP_I, 1, 1, s_trap());   push(OP_I, 0, 0, s_trap());
`else
    push(OP_BAD, 0, 0, f_wait());
`endif
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front();
      opcode = s.op; mem_ready = s.mr; branch_taken = s.bt;
      @(negedge clk);
      x = exp_q.pop_front();
      checks++;
      if ((obs() & x.m) !== (x.v & x.m)) begin
        failures++;
        $display("FAIL illegal cyc=%0d got=%h want=%h", cyc,
                 obs() & x.m, x.v & x.m);
      end
      @(posedge clk); #1; cyc++;
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (illegal !== 1'b0) begin
      failures++;
      $display("FAIL illegal_reset got=%b want=0", illegal);
    end
    @(negedge clk);
    rstn = 1'b1;
    ill_exp = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    opcode = 7'd0;
    mem_ready = 1'b0;
    branch_taken = 1'b0;
    test_reset();
    test_alu_ops();
    test_load();
    test_store();
    test_branch();
    test_jump();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM for the multicycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback.
- Drives the ALU A/B source selects, ALU op class, register/PC/IR write enables, result select and the memory request handshake.
- Sits between the instruction register decode fields and the datapath muxes.

Parameters:
- RESET_STATE_FETCH, 1: state entered on reset is FETCH. Fixed at 1; any other value is unsupported.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0]
- mem_ready  in  1  memory completes the current request this cycle
- branch_taken  in  1  comparator result for the current branch, valid in BRANCH
- alu_a_src  out  3  0 PC, 1 PC_BUF, 2 RD1_BUF, 3 RD1, 4 ZERO
- alu_b_src  out  2  0 RD2_BUF, 1 IMM, 2 CONST4
- alu_op  out  2  0 ADD, 1 BRANCH compare, 2 FUNCT (decoded downstream from funct3/funct7)
- result_src  out  2  0 ALU_OUT_BUF, 1 MEM_DATA_BUF, 2 ALU_RESULT
- pc_src  out  1  0 ALU_RESULT, 1 ALU_OUT_BUF
- addr_src  out  1  0 PC, 1 ALU_OUT_BUF
- pc_we, ir_we, rf_we, mem_req, mem_we  out  1 each  strobes
- illegal  out  1  sticky illegal-opcode flag (feature only)

Behaviour:
- Reset:
  - The state register is cleared asynchronously to FETCH.
  - All strobes are 0 while rstn=0. alu_a_src, alu_b_src and alu_op hold the FETCH values.
  - A reset asserted mid-access drops mem_req in the same cycle; no write enable fires.
- Output timing:
  - Outputs decode combinationally from the state.
  - Only pc_we/ir_we (FETCH), pc_we (BRANCH) and the MEM_* advance depend on inputs.
- The datapath latches alu_out_buf every cycle.
- States and per-state outputs (unlisted strobes are 0):
  - FETCH: addr_src=PC, mem_req=1, a=PC, b=CONST4, ADD, pc_src=ALU_RESULT.
    - mem_ready=1: pc_we=1, ir_we=1, go to DECODE.
    - mem_ready=0: stay in FETCH.
  - DECODE: a=PC_BUF, b=IMM, ADD (branch/JAL target into alu_out_buf).
    - Next state by opcode: 0110011 EXEC_R, 0010011 EXEC_I, 0000011/0100011 MEM_ADDR, 1100011 BRANCH, 1101111 JAL, 1100111 JALR_ADDR, 0110111 LUI, 0010111 AUIPC.
    - Any other opcode: FETCH, treated as a NOP.
  - EXEC_R: a=RD1_BUF, b=RD2_BUF, FUNCT. Next ALU_WB.
  - EXEC_I: a=RD1_BUF, b=IMM, FUNCT. Next ALU_WB.
  - LUI: a=ZERO, b=IMM, ADD. Next ALU_WB.
  - AUIPC: a=PC_BUF, b=IMM, ADD. Next ALU_WB.
  - ALU_WB: rf_we=1, result_src=ALU_OUT_BUF. Next FETCH.
  - MEM_ADDR: a=RD1_BUF, b=IMM, ADD. Next MEM_LOAD if opcode[5]=0, else MEM_STORE.
  - MEM_LOAD: mem_req=1, addr_src=ALU_OUT_BUF. Hold until mem_ready, then MEM_WB.
  - MEM_WB: rf_we=1, result_src=MEM_DATA_BUF. Next FETCH.
  - MEM_STORE: mem_req=1, mem_we=1, addr_src=ALU_OUT_BUF. Hold until mem_ready, then FETCH.
  - BRANCH: a=RD1_BUF, b=RD2_BUF, op BRANCH, pc_src=ALU_OUT_BUF, pc_we=branch_taken. Next FETCH.
  - JAL: a=PC_BUF, b=CONST4, ADD, rf_we=1, result_src=ALU_RESULT, pc_we=1, pc_src=ALU_OUT_BUF. Next FETCH.
  - JALR_ADDR: a=RD1_BUF, b=IMM, ADD. Next JALR_LINK.
  - JALR_LINK: outputs identical to JAL. Next FETCH. The datapath clears target bit 0.
- Cycle counts, FETCH to FETCH with mem_ready=1 on the first request cycle:
  - R/I/LUI/AUIPC: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 3
  - JALR: 4
- Each mem_ready wait cycle adds 1.
- mem_ready outside FETCH/MEM_LOAD/MEM_STORE is ignored.
- mem_req stays high, with stable addr_src/mem_we, until mem_ready is sampled high.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE enters TRAP, which holds forever with all strobes 0.
  - illegal becomes 1 on TRAP entry and stays 1 until rstn.
- Undefined: unknown opcodes return to FETCH, and illegal is tied 0.

Test Plan:
- Reset during FETCH wait (mem_ready=0, mem_req=1), rstn low -> mem_req=0 within the same cycle; state=FETCH after release; no pc_we/ir_we.
- ADDI (0010011), mem_ready=1 immediately -> 4 cycles; EXEC_I outputs a=2, b=1, op=2; ALU_WB has rf_we=1, result_src=0; exactly one pc_we and one ir_we.
- LW with mem_ready delayed 3 cycles in MEM_LOAD -> mem_req/addr_src=1 held 4 cycles; MEM_WB rf_we=1, result_src=1; 8 cycles total.
- BEQ, branch_taken=1 then a repeat with 0 -> pc_we=1 with pc_src=1 in BRANCH in the first case; pc_we=0 in the second; both return to FETCH after 3 cycles.
- JALR -> JALR_ADDR a=2, b=1; JALR_LINK a=1, b=2, rf_we=1, pc_we=1, pc_src=1, result_src=2.
- Opcode 1111111 -> with the macro: TRAP reached, illegal=1 and held, no strobes. Without it: back in FETCH after DECODE, illegal=0.
